instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter MAX_WAIT, default 8, SHALL set the number of consecutive un-acked request cycles that triggers a fetch error (legal range 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-004 PC  input  32  SHALL carry the current program counter from the PC counter stage.
REQ-005 pc_en  output  1  SHALL be a one-cycle pulse that advances the PC counter (drives its EN).
REQ-006 im_req  output  1  SHALL be the instruction-memory read request.
REQ-007 im_addr  output  32  SHALL be the instruction-memory read address.
REQ-008 im_ack  input  1  SHALL be the one-cycle memory acknowledge, qualifying im_rdata.
REQ-009 im_rdata  input  32  SHALL be the instruction word returned by memory.
REQ-010 instr  output  32  SHALL be the held instruction word.
REQ-011 instr_pc  output  32  SHALL be the address of the held instruction.
REQ-012 instr_valid  output  1  SHALL indicate instr/instr_pc are valid for decode.
REQ-013 instr_ready  input  1  SHALL indicate decode accepts the held instruction this cycle.
REQ-014 flush  input  1  SHALL discard any pending or held instruction (branch or jump redirect).
REQ-015 fetch_err  output  1  SHALL be a sticky memory-timeout error flag.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, REQ, HOLD, ERR.
REQ-017 IDLE SHALL last one cycle after reset release, then go to REQ; im_ack SHALL be ignored in IDLE.
REQ-018 In REQ: im_req SHALL be 1 and im_addr SHALL equal PC combinationally; PC is stable because pc_en is 0 in REQ.
REQ-019 In REQ, on im_ack=1 with flush=0: register im_rdata into instr and PC into instr_pc, then go to HOLD.
REQ-020 In every state other than REQ: im_req SHALL be 0 and im_addr SHALL be 0.
REQ-021 In HOLD, instr_valid SHALL be 1, and instr and instr_pc SHALL stay constant.
REQ-022 pc_en SHALL be 1 in exactly the first cycle of each HOLD visit and 0 at all other times.
REQ-023 In HOLD, on instr_ready=1 with flush=0: go to REQ next cycle; the earliest exit is at the end of the first HOLD cycle.
REQ-024 Latency: im_ack in cycle k SHALL give instr_valid=1 and pc_en=1 in cycle k+1; the next im_req comes no earlier than cycle k+2.
REQ-025 Wait counter (8 bit): cleared on entry to REQ; increments each REQ cycle that has no im_ack.
REQ-026 When the wait counter reaches MAX_WAIT with no im_ack: go to ERR and set fetch_err=1.
REQ-027 If im_ack arrives in the same cycle the counter reaches MAX_WAIT, the ack SHALL win and no error is raised.
REQ-028 flush=1 in REQ or HOLD: next state REQ, instr_valid=0 next cycle, no pc_en; an im_ack in the same cycle SHALL be discarded.
REQ-029 flush=1 in IDLE SHALL have no effect beyond the normal IDLE->REQ transition.
REQ-030 flush=1 in ERR SHALL be ignored.
REQ-031 ERR SHALL be absorbing until reset: im_req=0, instr_valid=0, pc_en=0, fetch_err=1.
REQ-032 im_ack outside REQ SHALL be ignored and SHALL NOT change any output.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force state IDLE and zero the wait counter.
REQ-034 rst_n=0 at a clock edge SHALL zero instr, instr_pc, instr_valid, pc_en, im_req and fetch_err.
REQ-035 Reset SHALL take priority over flush, im_ack and instr_ready.
REQ-036 Reset mid-transaction SHALL abandon the outstanding request; a late im_ack after release SHALL be ignored (REQ-017, REQ-032).

Verification
REQ-037 Reset release with PC=0x0000_0000 and im_ack in the 2nd REQ cycle with im_rdata=0x0000_0013 -> next cycle instr=0x0000_0013, instr_pc=0x0, instr_valid=1, pc_en=1 for exactly one cycle.
REQ-038 Back-to-back: instr_ready held at 1, PC steps 0x0->0x4->0x8, zero-wait acks -> three fetches, instr_pc=0x0,0x4,0x8, exactly one pc_en per fetch.
REQ-039 Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc unchanged, im_req=0, pc_en=1 only in the first HOLD cycle.
REQ-040 Flush with simultaneous im_ack (im_rdata=0xDEAD_BEEF) -> instr_valid=0 next cycle, no pc_en, a new request at the redirected PC follows.
REQ-041 MAX_WAIT=8, no im_ack for 8 REQ cycles -> ERR, fetch_err=1, im_req=0; a later flush or im_ack leaves it stuck; rst_n=0 clears fetch_err.
REQ-042 Ack on the 8th wait cycle (same cycle the counter hits MAX_WAIT) -> HOLD, fetch_err stays 0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus between the fetch stage and memory.
// Fetch drives the request/address; memory returns a one-cycle ack with data.
interface instr_fetch_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_ack,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ack,
    output im_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: requests one word per PC, holds it for decode,
// and latches a sticky error when memory never answers.
module instr_fetch #(
  parameter int MAX_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          PC,
  output logic                 pc_en,
  instr_fetch_if.master        im,
  output logic [31:0]          instr,
  output logic [31:0]          instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 flush,
  output logic                 fetch_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    ERR
  } state_t;

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  // Address only leaves the stage while a request is live.
  assign im.im_addr = im.im_req ? PC : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      pc_en       <= 1'b0;
      im.im_req   <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      pc_en <= 1'b0;
      unique case (state)
        IDLE: begin
          state     <= REQ;
          im.im_req <= 1'b1;
          wait_cnt  <= '0;
        end
        REQ: begin
          if (flush) begin
            wait_cnt <= '0;
          end else if (im.im_ack) begin
            state       <= HOLD;
            instr       <= im.im_rdata;
            instr_pc    <= PC;
            instr_valid <= 1'b1;
            pc_en       <= 1'b1;
            im.im_req   <= 1'b0;
          end else if (wait_cnt == LAST) begin
            state     <= ERR;
            fetch_err <= 1'b1;
            im.im_req <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (flush || instr_ready) begin
            state       <= REQ;
            instr_valid <= 1'b0;
            im.im_req   <= 1'b1;
            wait_cnt    <= '0;
          end
        end
        ERR: begin
          state <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, fetch latency, backpressure,
// flush and timeout behaviour with hand-computed expectations.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PC = '0;
  logic        pc_en;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        flush = 1'b0;
  logic        fetch_err;

  int passed = 0;
  int total  = 0;

  instr_fetch_if bus ();

  instr_fetch #(.MAX_WAIT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PC          (PC),
    .pc_en       (pc_en),
    .im          (bus.master),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .flush       (flush),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first REQ cycle.
  task automatic do_reset(input logic [31:0] pc0);
    rst_n = 1'b0;
    bus.im_ack = 1'b0;
    flush = 1'b0;
    instr_ready = 1'b0;
    PC = pc0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.im_ack = 1'b1;
    bus.im_rdata = 32'hFFFF_FFFF;
    flush = 1'b1;
    instr_ready = 1'b1;
    PC = 32'h0000_0040;
    tick();
    tick();
    total++; if (bus.im_req !== 1'b0) $display("FAIL rst_im_req got=%b exp=0", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h0) $display("FAIL rst_im_addr got=%h exp=0", bus.im_addr); else passed++;
    total++; if (instr !== 32'h0) $display("FAIL rst_instr got=%h exp=0", instr); else passed++;
    total++; if (instr_pc !== 32'h0) $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", instr_valid); else passed++;
    total++; if (pc_en !== 1'b0) $display("FAIL rst_pc_en got=%b exp=0", pc_en); else passed++;
    total++; if (fetch_err !== 1'b0) $display("FAIL rst_fetch_err got=%b exp=0", fetch_err); else passed++;
    bus.im_ack = 1'b0;
    flush = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic test_first_fetch();
    PC = 32'h0;
    rst_n = 1'b1;
    // IDLE cycle: an ack here must be ignored.
    bus.im_ack = 1'b1;
    bus.im_rdata = 32'hFFFF_FFFF;
    flush = 1'b1;
    tick();
    bus.im_ack = 1'b0;
    flush = 1'b0;
    total++; if (bus.im_req !== 1'b1) $display("FAIL ff_req1 got=%b exp=1", bus.im_req); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL ff_idle_ack got=%b exp=0", instr_valid); else passed++;
    total++; if (bus.im_addr !== 32'h0) $display("FAIL ff_addr got=%h exp=0", bus.im_addr); else passed++;
    tick();
    total++; if (bus.im_req !== 1'b1) $display("FAIL ff_req2 got=%b exp=1", bus.im_req); else passed++;
    bus.im_ack = 1'b1;
    bus.im_rdata = 32'h0000_0013;
    tick();
    bus.im_ack = 1'b0;
    total++; if (instr !== 32'h13) $display("FAIL ff_instr got=%h exp=00000013", instr); else passed++;
    total++; if (instr_pc !== 32'h0) $display("FAIL ff_instr_pc got=%h exp=0", instr_pc); else passed++;
    total++; if (instr_valid !== 1'b1) $display("FAIL ff_valid got=%b exp=1", instr_valid); else passed++;
    total++; if (pc_en !== 1'b1) $display("FAIL ff_pc_en got=%b exp=1", pc_en); else passed++;
    total++; if (bus.im_req !== 1'b0) $display("FAIL ff_hold_req got=%b exp=0", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h0) $display("FAIL ff_hold_addr got=%h exp=0", bus.im_addr); else passed++;
    tick();
    total++; if (pc_en !== 1'b0) $display("FAIL ff_pc_en_pulse got=%b exp=0", pc_en); else passed++;
    total++; if (instr_valid !== 1'b1) $display("FAIL ff_valid_held got=%b exp=1", instr_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    do_reset(32'h0);
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.im_addr !== PC) $display("FAIL b2b_addr%0d got=%h exp=%h", i, bus.im_addr, PC); else passed++;
      bus.im_ack = 1'b1;
      bus.im_rdata = 32'hA000_0000 + 32'(i);
      tick();
      bus.im_ack = 1'b0;
      if (pc_en === 1'b1) pulses++;
      total++; if (instr_pc !== 32'(4 * i)) $display("FAIL b2b_pc%0d got=%h exp=%h", i, instr_pc, 32'(4 * i)); else passed++;
      total++; if (instr !== 32'hA000_0000 + 32'(i)) $display("FAIL b2b_instr%0d got=%h exp=%h", i, instr, 32'hA000_0000 + 32'(i)); else passed++;
      total++; if (instr_valid !== 1'b1) $display("FAIL b2b_valid%0d got=%b exp=1", i, instr_valid); else passed++;
      PC = PC + 32'd4;
      tick();
      if (pc_en === 1'b1) pulses++;
      total++; if (bus.im_req !== 1'b1) $display("FAIL b2b_rereq%0d got=%b exp=1", i, bus.im_req); else passed++;
    end
    total++; if (pulses != 3) $display("FAIL b2b_pulses got=%0d exp=3", pulses); else passed++;
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset(32'h0000_0100);
    bus.im_ack = 1'b1;
    bus.im_rdata = 32'h1234_5678;
    tick();
    bus.im_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      // Late ack with different data must not disturb the held word.
      bus.im_ack = (c == 2);
      bus.im_rdata = 32'h5555_AAAA;
      total++; if (instr !== 32'h1234_5678) $display("FAIL bp_instr%0d got=%h exp=12345678", c, instr); else passed++;
      total++; if (instr_pc !== 32'h100) $display("FAIL bp_pc%0d got=%h exp=00000100", c, instr_pc); else passed++;
      total++; if (bus.im_req !== 1'b0) $display("FAIL bp_req%0d got=%b exp=0", c, bus.im_req); else passed++;
      total++; if (pc_en !== (c == 0)) $display("FAIL bp_pc_en%0d got=%b exp=%b", c, pc_en, (c == 0)); else passed++;
      tick();
    end
    bus.im_ack = 1'b0;
    total++; if (instr_valid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", instr_valid); else passed++;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total++; if (bus.im_req !== 1'b1) $display("FAIL bp_release got=%b exp=1", bus.im_req); else passed++;
  endtask

  task automatic test_flush();
    do_reset(32'h0000_0300);
    flush = 1'b1;
    bus.im_ack = 1'b1;
    bus.im_rdata = 32'hDEAD_BEEF;
    tick();
    flush = 1'b0;
    bus.im_ack = 1'b0;
    total++; if (instr_valid !== 1'b0) $display("FAIL fl_valid got=%b exp=0", instr_valid); else passed++;
    total++; if (pc_en !== 1'b0) $display("FAIL fl_pc_en got=%b exp=0", pc_en); else passed++;
    total++; if (instr === 32'hDEAD_BEEF) $display("FAIL fl_instr got=%h exp=not deadbeef", instr); else passed++;
    total++; if (bus.im_req !== 1'b1) $display("FAIL fl_req got=%b exp=1", bus.im_req); else passed++;
    PC = 32'h0000_0200;
    #1;
    total++; if (bus.im_addr !== 32'h200) $display("FAIL fl_redirect got=%h exp=00000200", bus.im_addr); else passed++;
    bus.im_ack = 1'b1;
    bus.im_rdata = 32'h0000_0067;
    tick();
    bus.im_ack = 1'b0;
    total++; if (instr_pc !== 32'h200) $display("FAIL fl_new_pc got=%h exp=00000200", instr_pc); else passed++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (instr_valid !== 1'b0) $display("FAIL fl_hold_valid got=%b exp=0", instr_valid); else passed++;
    total++; if (bus.im_req !== 1'b1) $display("FAIL fl_hold_req got=%b exp=1", bus.im_req); else passed++;
  endtask

  task automatic test_timeout();
    do_reset(32'h0000_0500);
    for (int c = 0; c < 7; c++) tick();
    total++; if (bus.im_req !== 1'b1) $display("FAIL to_req8 got=%b exp=1", bus.im_req); else passed++;
    total++; if (fetch_err !== 1'b0) $display("FAIL to_early_err got=%b exp=0", fetch_err); else passed++;
    tick();
    total++; if (fetch_err !== 1'b1) $display("FAIL to_err got=%b exp=1", fetch_err); else passed++;
    total++; if (bus.im_req !== 1'b0) $display("FAIL to_req got=%b exp=0", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h0) $display("FAIL to_addr got=%h exp=0", bus.im_addr); else passed++;
    flush = 1'b1;
    bus.im_ack = 1'b1;
    bus.im_rdata = 32'h0000_0013;
    instr_ready = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    bus.im_ack = 1'b0;
    instr_ready = 1'b0;
    total++; if (fetch_err !== 1'b1) $display("FAIL to_sticky got=%b exp=1", fetch_err); else passed++;
    total++; if (bus.im_req !== 1'b0) $display("FAIL to_stuck_req got=%b exp=0", bus.im_req); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL to_stuck_valid got=%b exp=0", instr_valid); else passed++;
    total++; if (pc_en !== 1'b0) $display("FAIL to_stuck_pc_en got=%b exp=0", pc_en); else passed++;
    rst_n = 1'b0;
    tick();
    total++; if (fetch_err !== 1'b0) $display("FAIL to_clear got=%b exp=0", fetch_err); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_ack_at_limit();
    do_reset(32'h0000_0600);
    for (int c = 0; c < 7; c++) tick();
    bus.im_ack = 1'b1;
    bus.im_rdata = 32'h0000_0093;
    tick();
    bus.im_ack = 1'b0;
    total++; if (fetch_err !== 1'b0) $display("FAIL lim_err got=%b exp=0", fetch_err); else passed++;
    total++; if (instr_valid !== 1'b1) $display("FAIL lim_valid got=%b exp=1", instr_valid); else passed++;
    total++; if (instr !== 32'h93) $display("FAIL lim_instr got=%h exp=00000093", instr); else passed++;
    total++; if (pc_en !== 1'b1) $display("FAIL lim_pc_en got=%b exp=1", pc_en); else passed++;
  endtask

  task automatic test_reset_mid_req();
    do_reset(32'h0000_0700);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    // Late ack in the IDLE cycle after release.
    bus.im_ack = 1'b1;
    bus.im_rdata = 32'hCAFE_F00D;
    tick();
    bus.im_ack = 1'b0;
    total++; if (instr_valid !== 1'b0) $display("FAIL mid_valid got=%b exp=0", instr_valid); else passed++;
    total++; if (instr !== 32'h0) $display("FAIL mid_instr got=%h exp=0", instr); else passed++;
    total++; if (bus.im_req !== 1'b1) $display("FAIL mid_req got=%b exp=1", bus.im_req); else passed++;
  endtask

  initial begin
    bus.im_ack = 1'b0;
    bus.im_rdata = '0;
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end
endmodule
